// File: rtl/sdr_mon_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdr_mon_pkg : record/state types for sdr_app_txn_monitor (SDR_MON_DATA_CRC_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
package sdr_mon_pkg;

  localparam int SDR_MON_AW = 26;
  localparam int SDR_MON_DW = 32;
  localparam int SDR_MON_BL = 9;

  localparam int ERR_ZERO_LEN  = 0;
  localparam int ERR_LAST_MISS = 1;
  localparam int ERR_TIMEOUT   = 2;
  localparam int ERR_OVERLAP   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_e;

  typedef struct packed {
    logic                  wr_n;
    logic [SDR_MON_AW-1:0] addr;
    logic [SDR_MON_BL-1:0] len;
    logic [SDR_MON_BL-1:0] beats;
    logic [3:0]            err;
`ifdef SDR_MON_DATA_CRC_EN
    logic [31:0]           crc;
`endif
  } txn_rec_t;

`ifdef SDR_MON_DATA_CRC_EN
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // MSB-first, non-reflected CRC-32 over one 32-bit word.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                             input logic [31:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction
`endif

endpackage : sdr_mon_pkg
`default_nettype wire

// File: rtl/sdr_mon_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdr_mon_fifo : synchronous record FIFO, registered head, pop-then-push when full
// Rev 1.0
// ----------------------------------------------------------------------------
module sdr_mon_fifo
  import sdr_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  txn_rec_t push_rec,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output txn_rec_t head
);

  localparam int PW = $clog2(DEPTH);

  txn_rec_t       mem [DEPTH];
  logic [PW:0]    wr_ptr;
  logic [PW:0]    rd_ptr;
  logic           do_pop;
  logic           do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= push_rec;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Stale entries are masked so an empty FIFO presents an all-zero record.
  assign head = empty ? '0 : mem[rd_ptr[PW-1:0]];

endmodule : sdr_mon_fifo
`default_nettype wire

// File: rtl/sdr_app_txn_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdr_app_txn_monitor : passive SDRAM app-side transaction recorder (SDR_MON_DATA_CRC_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
module sdr_app_txn_monitor
  import sdr_mon_pkg::*;
#(
  parameter int APP_AW      = SDR_MON_AW,
  parameter int dw          = SDR_MON_DW,
  parameter int bl          = SDR_MON_BL,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic              mon_req,
  input  logic              mon_req_ack,
  input  logic [APP_AW-1:0] mon_req_addr,
  input  logic [bl-1:0]     mon_req_len,
  input  logic              mon_req_wr_n,
  input  logic              mon_wr_next,
  input  logic              mon_rd_valid,
  input  logic              mon_last_wr,
  input  logic              mon_last_rd,
  input  logic [dw-1:0]     mon_wr_data,
  input  logic [dw-1:0]     mon_rd_data,
  output logic              txn_valid,
  input  logic              txn_ready,
  output txn_rec_t          txn_rec,
  output logic              mon_busy,
  output logic [3:0]        err_sticky,
  output logic [7:0]        drop_cnt,
  input  logic              clr_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYC);

  state_e             state;
  state_e             state_nx;
  logic               cur_wr_n;
  logic [APP_AW-1:0]  cur_addr;
  logic [bl-1:0]      cur_len;
  logic [bl-1:0]      beats;
  logic [WD_W-1:0]    wdog;
  logic               ovl;

  logic               accept;
  logic               open;
  logic               beat;
  logic               last;
  logic [bl-1:0]      beats_inc;
  logic               hit_len;
  logic               early;
  logic               timeout;
  logic               close;
  logic               zero_len;
  logic               overlap;
  logic               push;
  txn_rec_t           push_rec;
  logic               fifo_full;
  logic               fifo_empty;
  logic               drop;
  logic [3:0]         new_err;
  logic [7:0]         drop_base;

`ifdef SDR_MON_DATA_CRC_EN
  logic [31:0]        crc;
  logic [31:0]        crc_upd;
  assign crc_upd = crc32_next(crc, (state == WR) ? mon_wr_data : mon_rd_data);
`else
  logic               unused_data;
  assign unused_data = ^{mon_wr_data, mon_rd_data};
`endif

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) state <= IDLE;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = mon_req && mon_req_ack;
    open      = (state != IDLE);
    beat      = 1'b0;
    last      = 1'b0;
    beats_inc = beats + 1'b1;
    if (state == WR) begin
      beat = mon_wr_next;
      last = mon_last_wr;
    end else if (state == RD) begin
      beat = mon_rd_valid;
      last = mon_last_rd;
    end
    hit_len  = beat && (beats_inc == cur_len);
    early    = beat && last && !hit_len;
    timeout  = open && !beat && (wdog == WD_W'(TIMEOUT_CYC - 1));
    close    = open && (hit_len || early || timeout);
    zero_len = !open && accept && (mon_req_len == '0);
    overlap  = open && accept;
    push     = close || zero_len;

    push_rec = '0;
    if (zero_len) begin
      push_rec.wr_n              = mon_req_wr_n;
      push_rec.addr              = mon_req_addr;
      push_rec.err[ERR_ZERO_LEN] = 1'b1;
`ifdef SDR_MON_DATA_CRC_EN
      push_rec.crc               = CRC_INIT;
`endif
    end else begin
      push_rec.wr_n               = cur_wr_n;
      push_rec.addr               = cur_addr;
      push_rec.len                = cur_len;
      push_rec.beats              = beat ? beats_inc : beats;
      push_rec.err[ERR_LAST_MISS] = (hit_len && !last) || early;
      push_rec.err[ERR_TIMEOUT]   = timeout;
      push_rec.err[ERR_OVERLAP]   = ovl || overlap;
`ifdef SDR_MON_DATA_CRC_EN
      push_rec.crc                = beat ? crc_upd : crc;
`endif
    end

    case (state)
      IDLE:    if (accept && (mon_req_len != '0)) state_nx = mon_req_wr_n ? RD : WR;
      WR, RD:  if (close) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      cur_wr_n <= 1'b0;
      cur_addr <= '0;
      cur_len  <= '0;
      beats    <= '0;
      wdog     <= '0;
      ovl      <= 1'b0;
`ifdef SDR_MON_DATA_CRC_EN
      crc      <= CRC_INIT;
`endif
    end else if (!open) begin
      if (accept) begin
        cur_wr_n <= mon_req_wr_n;
        cur_addr <= mon_req_addr;
        cur_len  <= mon_req_len;
        beats    <= '0;
        wdog     <= '0;
        ovl      <= 1'b0;
`ifdef SDR_MON_DATA_CRC_EN
        crc      <= CRC_INIT;
`endif
      end
    end else begin
      if (beat) begin
        beats <= beats_inc;
        wdog  <= '0;
`ifdef SDR_MON_DATA_CRC_EN
        crc   <= crc_upd;
`endif
      end else begin
        wdog <= wdog + 1'b1;
      end
      if (overlap) ovl <= 1'b1;
    end
  end

  sdr_mon_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sdram_clk),
    .rst_n    (sdram_resetn),
    .push     (push),
    .push_rec (push_rec),
    .pop      (txn_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (txn_rec)
  );

  assign txn_valid = !fifo_empty;
  assign mon_busy  = open;

  // A push into a full FIFO survives only if the head leaves on the same edge.
  assign drop      = push && fifo_full && !(txn_valid && txn_ready);
  assign new_err   = (push ? push_rec.err : 4'b0) | {drop, 3'b000};
  assign drop_base = clr_err ? 8'd0 : drop_cnt;

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      err_sticky <= 4'b0;
      drop_cnt   <= 8'd0;
    end else begin
      err_sticky <= (clr_err ? 4'b0 : err_sticky) | new_err;
      drop_cnt   <= (drop && (drop_base != 8'hFF)) ? drop_base + 8'd1 : drop_base;
    end
  end

endmodule : sdr_app_txn_monitor
`default_nettype wire

// File: tb/tb_sdr_app_txn_monitor.sv
`default_nettype none
// Bench for sdr_app_txn_monitor: transaction-level model with a record queue, plus literal checks.
module tb_sdr_app_txn_monitor;
  import sdr_mon_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mon_req = 1'b0, mon_req_ack = 1'b0, mon_req_wr_n = 1'b0;
  logic [25:0] mon_req_addr = '0;
  logic [8:0]  mon_req_len = '0;
  logic        mon_wr_next = 1'b0, mon_rd_valid = 1'b0;
  logic        mon_last_wr = 1'b0, mon_last_rd = 1'b0;
  logic [31:0] mon_wr_data = '0, mon_rd_data = '0;
  logic        txn_valid, txn_ready = 1'b0, mon_busy, clr_err = 1'b0;
  txn_rec_t    txn_rec;
  logic [3:0]  err_sticky;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

  sdr_app_txn_monitor #(
    .APP_AW(26), .dw(32), .bl(9), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .sdram_clk(clk), .sdram_resetn(rst_n),
    .mon_req(mon_req), .mon_req_ack(mon_req_ack), .mon_req_addr(mon_req_addr),
    .mon_req_len(mon_req_len), .mon_req_wr_n(mon_req_wr_n),
    .mon_wr_next(mon_wr_next), .mon_rd_valid(mon_rd_valid),
    .mon_last_wr(mon_last_wr), .mon_last_rd(mon_last_rd),
    .mon_wr_data(mon_wr_data), .mon_rd_data(mon_rd_data),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_rec(txn_rec),
    .mon_busy(mon_busy), .err_sticky(err_sticky), .drop_cnt(drop_cnt),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bytewise CRC-32 (MSB-first, poly 0x04C11DB7) of one word, high byte first.
  function automatic logic [31:0] crc_word(input logic [31:0] c_in, input logic [31:0] w);
    logic [31:0] c;
    c = c_in;
    for (int b = 3; b >= 0; b--) begin
      c = c ^ {w[b*8 +: 8], 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  // ---------------- model ----------------
  txn_rec_t    q[$];
  bit          m_open, m_wr_n, m_ovl, m_got, m_beat, m_last;
  logic [25:0] m_addr;
  int          m_len, m_beats, m_idle, m_drop;
  logic [31:0] m_crc;
  logic [3:0]  m_sticky;
  txn_rec_t    m_rec;

  function automatic txn_rec_t mk(input logic [3:0] err);
    txn_rec_t r;
    r = '0;
    r.wr_n  = m_wr_n;
    r.addr  = m_addr;
    r.len   = 9'(m_len);
    r.beats = 9'(m_beats);
    r.err   = err | {m_ovl, 3'b000};
`ifdef SDR_MON_DATA_CRC_EN
    r.crc   = m_crc;
`endif
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_open = 0; m_sticky = '0; m_drop = 0;
    end else begin
      if (q.size() > 0 && txn_ready) void'(q.pop_front());
      m_got = 0;
      if (m_open) begin
        m_beat = m_wr_n ? mon_rd_valid : mon_wr_next;
        m_last = m_wr_n ? mon_last_rd : mon_last_wr;
        if (mon_req && mon_req_ack) m_ovl = 1;
        if (m_beat) begin
          m_beats++;
          m_idle = 0;
          m_crc = crc_word(m_crc, m_wr_n ? mon_rd_data : mon_wr_data);
          if (m_beats == m_len) begin m_rec = mk(m_last ? 4'b0000 : 4'b0010); m_got = 1; end
          else if (m_last)      begin m_rec = mk(4'b0010); m_got = 1; end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin m_rec = mk(4'b0100); m_got = 1; end
        end
        if (m_got) m_open = 0;
      end else if (mon_req && mon_req_ack) begin
        m_wr_n = mon_req_wr_n; m_addr = mon_req_addr; m_len = int'(mon_req_len);
        m_beats = 0; m_idle = 0; m_ovl = 0; m_crc = 32'hFFFFFFFF;
        if (m_len == 0) begin m_rec = mk(4'b0001); m_got = 1; end
        else m_open = 1;
      end
      if (clr_err) begin m_sticky = '0; m_drop = 0; end
      if (m_got) begin
        m_sticky |= m_rec.err;
        if (q.size() < DEPTH) q.push_back(m_rec);
        else begin
          m_sticky[3] = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 128'(txn_valid), 128'(q.size() > 0));
      chk("rec", 128'(txn_rec), (q.size() > 0) ? 128'(q[0]) : 128'(0));
      chk("busy", 128'(mon_busy), 128'(m_open));
      chk("sticky", 128'(err_sticky), 128'(m_sticky));
      chk("drop", 128'(drop_cnt), 128'(m_drop));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input logic wr_n, input logic [25:0] addr, input logic [8:0] len);
    mon_req = 1; mon_req_ack = 1; mon_req_wr_n = wr_n; mon_req_addr = addr; mon_req_len = len;
    cyc(1);
    mon_req = 0; mon_req_ack = 0;
  endtask

  task automatic beats(input bit wr, input int n, input int last_at, input bit zdata);
    for (int i = 1; i <= n; i++) begin
      mon_wr_next = wr; mon_rd_valid = !wr;
      mon_last_wr = wr && (i == last_at);
      mon_last_rd = !wr && (i == last_at);
      mon_wr_data = zdata ? 32'h0 : $urandom;
      mon_rd_data = zdata ? 32'h0 : $urandom;
      cyc(1);
      mon_wr_next = 0; mon_rd_valid = 0; mon_last_wr = 0; mon_last_rd = 0;
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_valid", 128'(txn_valid), 128'(0));
    chk("rst_rec", 128'(txn_rec), 128'(0));
    chk("rst_busy", 128'(mon_busy), 128'(0));
    chk("rst_sticky", 128'(err_sticky), 128'(0));
    chk("rst_drop", 128'(drop_cnt), 128'(0));
    rst_n = 1;
    cyc(2);

    // Clean write, len 4
    request(1'b0, 26'h100, 9'd4);
    chk("wr_busy", 128'(mon_busy), 128'(1));
    beats(1, 4, 4, 0);
    chk("wr_valid", 128'(txn_valid), 128'(1));
    chk("wr_rec", 128'({txn_rec.wr_n, txn_rec.addr, txn_rec.len, txn_rec.beats, txn_rec.err}),
        128'({1'b0, 26'h100, 9'd4, 9'd4, 4'b0000}));
    txn_ready = 1; cyc(1); txn_ready = 0;

    // Read len 8, early last on beat 5
    request(1'b1, 26'h2000, 9'd8);
    beats(0, 5, 5, 0);
    chk("early_beats", 128'(txn_rec.beats), 128'(5));
    chk("early_err", 128'(txn_rec.err), 128'(4'b0010));
    chk("early_sticky1", 128'(err_sticky[1]), 128'(1));
    txn_ready = 1; cyc(1); txn_ready = 0;
    clr_err = 1; cyc(1); clr_err = 0;
    chk("clr_sticky", 128'(err_sticky), 128'(0));

    // Read len 2, one beat then silence
    request(1'b1, 26'h3000, 9'd2);
    beats(0, 1, 0, 0);
    cyc(TIMEOUT - 2);
    chk("to_open", 128'(mon_busy), 128'(1));
    cyc(8);
    chk("to_valid", 128'(txn_valid), 128'(1));
    chk("to_beats", 128'(txn_rec.beats), 128'(1));
    chk("to_err", 128'(txn_rec.err), 128'(4'b0100));
    txn_ready = 1; cyc(1); txn_ready = 0;

    // Overflow: five closes with consumer stalled
    for (int i = 0; i < 5; i++) begin
      request(1'b0, 26'h4000 + 26'(i), 9'd1);
      beats(1, 1, 1, 0);
    end
    chk("ovf_drop", 128'(drop_cnt), 128'(1));
    chk("ovf_sticky3", 128'(err_sticky[3]), 128'(1));
    txn_ready = 1; cyc(5); txn_ready = 0;
    clr_err = 1; cyc(1); clr_err = 0;
    for (int i = 0; i < 4; i++) begin
      request(1'b0, 26'h4100 + 26'(i), 9'd1);
      beats(1, 1, 1, 0);
    end
    request(1'b0, 26'h4104, 9'd1);
    txn_ready = 1;
    beats(1, 1, 1, 0);
    chk("poppush_drop", 128'(drop_cnt), 128'(0));
    cyc(6);

    // Overlapping ack during an open write; reads during the write are ignored
    request(1'b0, 26'h500, 9'd4);
    beats(1, 1, 0, 0);
    mon_rd_valid = 1;
    request(1'b1, 26'h600, 9'd2);
    mon_rd_valid = 0;
    beats(1, 3, 3, 0);
    chk("ovl_sticky3", 128'(err_sticky[3]), 128'(1));
    cyc(3);
    chk("ovl_idle", 128'(mon_busy), 128'(0));

    // Zero-length request
    request(1'b0, 26'h700, 9'd0);
    chk("zero_valid", 128'(txn_valid), 128'(1));
    chk("zero_err", 128'(txn_rec.err), 128'(4'b0001));
    chk("zero_busy", 128'(mon_busy), 128'(0));
    cyc(2);

`ifdef SDR_MON_DATA_CRC_EN
    txn_ready = 0;
    request(1'b0, 26'h900, 9'd1);
    beats(1, 1, 1, 1);
    chk("crc_zero", 128'(txn_rec.crc), 128'(crc_word(32'hFFFFFFFF, 32'h0)));
    txn_ready = 1; cyc(1);
    request(1'b0, 26'h904, 9'd0);
    chk("crc_len0_err", 128'(txn_rec.err[0]), 128'(1));
    cyc(2);
`endif

    // Reset in the middle of a write
    txn_ready = 0;
    request(1'b0, 26'h800, 9'd4);
    beats(1, 1, 0, 0);
    @(posedge clk); #2 rst_n = 0;
    cyc(2);
    rst_n = 1;
    cyc(2);
    chk("mid_rst_valid", 128'(txn_valid), 128'(0));
    chk("mid_rst_busy", 128'(mon_busy), 128'(0));
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sdr_app_txn_monitor
`default_nettype wire
